merge_pair_scheduler: RTL

Sequences a 2-element bitonic compare-swap stage inside the 1-merger.
- Merges two sorted input streams (A, B) one element per cycle, smaller head first.
- Gathers merged elements into pairs and issues each pair to the network with stall and switch_output control.
- Detects end-of-run terminal tuples, flushes partial pairs and marks run boundaries.

---
 rtl/merge_sched_pkg.sv | 22 ++
 rtl/merge_pair_scheduler_pair_gather.sv | 72 +++++++
 rtl/merge_pair_scheduler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/merge_sched_pkg.sv
// Shared types and constants for the merge pair scheduler: FSM state encoding,
// default widths/terminal value and the merge comparison helper.
package merge_sched_pkg;

  localparam int          DEF_DW   = 32;
  localparam int          DEF_CW   = 16;
  localparam logic [63:0] DEF_TERM = 64'd0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MERGE   = 3'd1,
    ST_DRAIN_A = 3'd2,
    ST_DRAIN_B = 3'd3,
    ST_FLUSH   = 3'd4
  } state_e;

  // Returns 1 when A should be taken; ties go to A so the merge is stable.
  function automatic logic tuple_min_sel(input logic [63:0] a, input logic [63:0] b);
    return (a <= b);
  endfunction

endpackage

// File: rtl/merge_pair_scheduler_pair_gather.sv
// Pair gather stage: holds the first element of a pair, registers each issued
// pair with its stall/switch flags and tracks the larger element of the last issue.
module pair_gather
  import merge_sched_pkg::*;
#(
  parameter int             DW   = DEF_DW,
  parameter logic [DW-1:0]  TERM = DEF_TERM[DW-1:0]
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          pick_i,
  input  logic [DW-1:0] pick_data_i,
  input  logic          flush_i,
  output logic [DW-1:0] elems_0_o,
  output logic [DW-1:0] elems_1_o,
  output logic          stall_o,
  output logic          switch_o,
  output logic [DW-1:0] top_tuple_o
);

  logic [DW-1:0] slot0_q;
  logic          full_q;
  logic [DW-1:0] elems_0_q, elems_1_q, top_q;
  logic          stall_q, switch_q;

  logic          issue_d;
  logic [DW-1:0] iss0_d, iss1_d;

  // A flush closes the run: a half-filled pair is padded with the terminal tuple.
  always_comb begin
    issue_d = flush_i | (pick_i & full_q);
    iss0_d  = slot0_q;
    iss1_d  = pick_data_i;
    if (flush_i) begin
      iss0_d = full_q ? slot0_q : TERM;
      iss1_d = TERM;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot0_q   <= '0;
      full_q    <= 1'b0;
      elems_0_q <= '0;
      elems_1_q <= '0;
      top_q     <= '0;
      stall_q   <= 1'b1;
      switch_q  <= 1'b0;
    end else begin
      stall_q <= ~issue_d;
      if (issue_d) begin
        elems_0_q <= iss0_d;
        elems_1_q <= iss1_d;
        switch_q  <= flush_i;
        top_q     <= (iss0_d > iss1_d) ? iss0_d : iss1_d;
      end
      if (issue_d) begin
        full_q <= 1'b0;
      end else if (pick_i) begin
        slot0_q <= pick_data_i;
        full_q  <= 1'b1;
      end
    end
  end

  assign elems_0_o   = elems_0_q;
  assign elems_1_o   = elems_1_q;
  assign stall_o     = stall_q;
  assign switch_o    = switch_q;
  assign top_tuple_o = top_q;

endmodule

// File: rtl/merge_pair_scheduler.sv
// Merges two sorted tuple streams into compare-swap pairs with run-boundary flush.
// Optional MERGE_SCHED_STATS_EN adds issue/backpressure/starvation counters.
module merge_pair_scheduler
  import merge_sched_pkg::*;
#(
  parameter int            DW   = DEF_DW,
  parameter logic [DW-1:0] TERM = DEF_TERM[DW-1:0],
  parameter int            CW   = DEF_CW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] i_a_data,
  input  logic          i_a_valid,
  output logic          o_a_pop,
  input  logic [DW-1:0] i_b_data,
  input  logic          i_b_valid,
  output logic          o_b_pop,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_elems_0,
  output logic [DW-1:0] o_elems_1,
  output logic          o_stall,
  output logic          o_switch_output,
  output logic [DW-1:0] o_top_tuple,
  output logic [CW-1:0] o_run_count,
  output logic [2:0]    o_dbg_state
`ifdef MERGE_SCHED_STATS_EN
  ,
  output logic [31:0]   o_issue_cnt,
  output logic [31:0]   o_bp_cnt,
  output logic [31:0]   o_starve_cnt
`endif
);

  // Handshake: a head is consumed when its pop is high while its valid is high;
  // pops are only raised when i_out_ready=1, otherwise the whole block holds.
  state_e        state_q, state_d;
  logic [CW-1:0] run_cnt_q;
  logic          pick_a, pick_b, flush_go;
  logic          a_term, b_term;
  logic [DW-1:0] pick_data;

  assign a_term = i_a_valid && (i_a_data == TERM);
  assign b_term = i_b_valid && (i_b_data == TERM);

  always_comb begin
    state_d  = state_q;
    pick_a   = 1'b0;
    pick_b   = 1'b0;
    flush_go = 1'b0;
    case (state_q)
      ST_IDLE: if (i_a_valid || i_b_valid) state_d = ST_MERGE;
      ST_MERGE: begin
        if (a_term && b_term)            state_d = ST_FLUSH;
        else if (a_term)                 state_d = ST_DRAIN_B;
        else if (b_term)                 state_d = ST_DRAIN_A;
        else if (i_a_valid && i_b_valid) begin
          if (tuple_min_sel(64'(i_a_data), 64'(i_b_data))) pick_a = 1'b1;
          else                                             pick_b = 1'b1;
        end
      end
      ST_DRAIN_A: begin
        if (a_term)         state_d = ST_FLUSH;
        else if (i_a_valid) pick_a  = 1'b1;
      end
      ST_DRAIN_B: begin
        if (b_term)         state_d = ST_FLUSH;
        else if (i_b_valid) pick_b  = 1'b1;
      end
      ST_FLUSH: begin
        flush_go = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!i_out_ready) begin
      state_d  = state_q;
      pick_a   = 1'b0;
      pick_b   = 1'b0;
      flush_go = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      run_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush_go)                                   run_cnt_q <= '0;
      else if ((pick_a || pick_b) && run_cnt_q != '1) run_cnt_q <= run_cnt_q + CW'(1);
    end
  end

  assign pick_data   = pick_a ? i_a_data : i_b_data;
  assign o_a_pop     = pick_a | flush_go;
  assign o_b_pop     = pick_b | flush_go;
  assign o_run_count = run_cnt_q;
  assign o_dbg_state = state_q;

  pair_gather #(.DW(DW), .TERM(TERM)) u_gather (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .pick_i      (pick_a | pick_b),
    .pick_data_i (pick_data),
    .flush_i     (flush_go),
    .elems_0_o   (o_elems_0),
    .elems_1_o   (o_elems_1),
    .stall_o     (o_stall),
    .switch_o    (o_switch_output),
    .top_tuple_o (o_top_tuple)
  );

`ifdef MERGE_SCHED_STATS_EN
  logic [31:0] issue_cnt_q, bp_cnt_q, starve_cnt_q;
  logic        starve;

  assign starve = (state_q == ST_MERGE && !a_term && !b_term && !(i_a_valid && i_b_valid)) ||
                  (state_q == ST_DRAIN_A && !i_a_valid) ||
                  (state_q == ST_DRAIN_B && !i_b_valid);

  // Every issue shows up as exactly one stall-low cycle, so counting those counts issues.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      issue_cnt_q  <= '0;
      bp_cnt_q     <= '0;
      starve_cnt_q <= '0;
    end else begin
      if (!o_stall)                            issue_cnt_q  <= issue_cnt_q + 32'd1;
      if (!i_out_ready && state_q != ST_IDLE)  bp_cnt_q     <= bp_cnt_q + 32'd1;
      if (starve)                              starve_cnt_q <= starve_cnt_q + 32'd1;
    end
  end

  assign o_issue_cnt  = issue_cnt_q;
  assign o_bp_cnt     = bp_cnt_q;
  assign o_starve_cnt = starve_cnt_q;
`endif

endmodule
